// File: rtl/n101_subsys_gpio_irq_arb_pkg.sv
// Shared constants for the GPIO interrupt conditioner / arbiter.
package n101_subsys_gpio_irq_arb_pkg;

   localparam int GPIO_IRQ_NUM = 32;
   localparam int GPIO_ID_W    = 5;

   // Arbitration policy encodings
   localparam int ARB_FIXED = 0;
   localparam int ARB_RR    = 1;

   // Handshake FSM
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_GAP  = 2'd2
   } arb_state_e;

endpackage

// File: rtl/n101_subsys_irq_rr_pick.sv
// Rotate-priority encoder: first set bit of req at or above start, wrapping
// modulo N. With start tied to 0 it degenerates to a lowest-index encoder.
module n101_subsys_irq_rr_pick #(
   parameter int N = 32,
   parameter int W = 5
) (
   input  logic [N-1:0] req,
   input  logic [W-1:0] start,
   output logic         any,
   output logic [W-1:0] idx
);

   logic [2*N-1:0] dbl;
   logic [N-1:0]   rot;
   logic [W:0]     sum;

   // Rotate req so bit 0 is the start position, find the lowest set bit,
   // then map the offset back to an absolute index with an explicit wrap at N.
   always_comb begin
      dbl = {req, req} >> start;
      rot = dbl[N-1:0];
      any = |rot;
      sum = '0;
      for (int k = N-1; k >= 0; k--) begin
         if (rot[k]) sum = {1'b0, start} + (W+1)'(k);
      end
      if (int'(sum) >= N) sum = sum - (W+1)'(N);
      idx = sum[W-1:0];
   end

endmodule

// File: rtl/n101_subsys_gpio_irq_arb.sv
// GPIO interrupt conditioning and serialisation onto a single CLIC input.
// Each line is synchronised, qualified as edge or level, and pending lines
// are granted one at a time through an irq_req / irq_ack handshake.
import n101_subsys_gpio_irq_arb_pkg::*;

module n101_subsys_gpio_irq_arb #(
   parameter int IRQ_NUM     = GPIO_IRQ_NUM,
   parameter int ID_W        = GPIO_ID_W,
   parameter int SYNC_STAGES = 2,
   parameter int ARB_MODE    = ARB_RR
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [IRQ_NUM-1:0] gpio_irq,
   input  logic [IRQ_NUM-1:0] cfg_en,
   input  logic [IRQ_NUM-1:0] cfg_edge,
   output logic               irq_req,
   output logic [ID_W-1:0]    irq_id,
   input  logic               irq_ack,
   output logic [IRQ_NUM-1:0] irq_pend
);

   logic [IRQ_NUM-1:0] sync_q [SYNC_STAGES];
   logic [IRQ_NUM-1:0] prev_q;
   logic [IRQ_NUM-1:0] pend_q;
   logic [IRQ_NUM-1:0] s;
   logic [IRQ_NUM-1:0] rise;
   logic [IRQ_NUM-1:0] clr;
   logic [IRQ_NUM-1:0] eff;

   arb_state_e         state, state_nxt;
   logic [ID_W-1:0]    id_nxt;
   logic [ID_W-1:0]    rr_ptr, rr_nxt;
   logic [ID_W-1:0]    pick_start;
   logic [ID_W-1:0]    pick_idx;
   logic               pick_any;
   logic               ack_go;

   assign s    = sync_q[SYNC_STAGES-1];
   assign rise = s & ~prev_q & cfg_en & cfg_edge;
   assign clr  = ack_go ? (IRQ_NUM'(1) << irq_id) : '0;

   // Edge lines report the latch, level lines the live synchronised input.
   assign eff      = ((cfg_edge & pend_q) | (~cfg_edge & s)) & cfg_en;
   assign irq_pend = eff;
   assign irq_req  = (state == ST_REQ);

   // Synchroniser chain plus one-cycle delayed copy for edge detection.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
         prev_q <= '0;
      end else begin
         sync_q[0] <= gpio_irq;
         for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
         prev_q <= s;
      end
   end

   // Pending latch for edge lines: set beats clear so a new edge landing on
   // the ack cycle is kept; disabled or level lines hold 0.
   always_ff @(posedge clk) begin
      if (rst) pend_q <= '0;
      else     pend_q <= (rise | (pend_q & ~clr)) & cfg_en & cfg_edge;
   end

   assign pick_start = (ARB_MODE == ARB_RR) ? rr_ptr : '0;

   n101_subsys_irq_rr_pick #(
      .N (IRQ_NUM),
      .W (ID_W)
   ) u_pick (
      .req   (eff),
      .start (pick_start),
      .any   (pick_any),
      .idx   (pick_idx)
   );

   // Handshake state, granted ID and round-robin pointer registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= ST_IDLE;
         irq_id <= '0;
         rr_ptr <= '0;
      end else begin
         state  <= state_nxt;
         irq_id <= id_nxt;
         rr_ptr <= rr_nxt;
      end
   end

   // Grant in IDLE, hold through REQ until ack, then one forced low cycle.
   always_comb begin
      state_nxt = state;
      id_nxt    = irq_id;
      rr_nxt    = rr_ptr;
      ack_go    = 1'b0;
      case (state)
         ST_IDLE: begin
            if (pick_any) begin
               id_nxt    = pick_idx;
               state_nxt = ST_REQ;
            end
         end
         ST_REQ: begin
            if (irq_ack) begin
               ack_go    = 1'b1;
               state_nxt = ST_GAP;
               if (ARB_MODE == ARB_RR)
                  rr_nxt = (irq_id == ID_W'(IRQ_NUM-1)) ? '0 : irq_id + 1'b1;
            end
         end
         ST_GAP:  state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

endmodule
